// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write-only bus controller:
// FSM state encoding, default phase timings and instruction codes.
package lcd_pkg;

  // Default phase timings in clock cycles.
  localparam int T_PWRUP_DEF     = 750000;
  localparam int T_SETUP_DEF     = 2;
  localparam int T_EN_DEF        = 12;
  localparam int T_HOLD_DEF      = 2;
  localparam int T_EXEC_DEF      = 2500;
  localparam int T_EXEC_LONG_DEF = 82000;

  // Instructions that need the long execution wait.
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_HOME     = 8'h02;
  // Return-home ignores bit 0, so 0x03 is also a home command.
  localparam logic [7:0] LCD_HOME_ALT = 8'h03;

  typedef enum logic [2:0] {
    PWRUP,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } lcd_state_e;

  // A phase configured as 0 cycles still lasts one cycle.
  function automatic int eff_cycles(input int t);
    return (t < 1) ? 1 : t;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear and home are slow on the panel; everything else uses the short wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CLEAR || data == LCD_HOME || data == LCD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable phase down-counter. Counts to zero and stops there;
// o_done is high while the count is zero.
module lcd_timer #(
  parameter int W = 20
) (
  input  logic         i_clk,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] cnt;

  // Reload on request, otherwise count down and saturate at zero.
  // NOTE: no reset branch here; the controller asserts i_load during reset,
  // so the counter is initialised through the load path instead.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      cnt <= i_load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign o_done = (cnt == '0);

endmodule

// File: rtl/lcd_bus_ctrl.sv
// Write-only HD44780 bus controller. Sequences each accepted command through
// setup, enable pulse, hold and execution wait, then reopens for the next one.
module lcd_bus_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP     = T_PWRUP_DEF,
  parameter int T_SETUP     = T_SETUP_DEF,
  parameter int T_EN        = T_EN_DEF,
  parameter int T_HOLD      = T_HOLD_DEF,
  parameter int T_EXEC      = T_EXEC_DEF,
  parameter int T_EXEC_LONG = T_EXEC_LONG_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_vld,
  output logic        o_cmd_rdy,
  input  logic        i_cmd_rs,
  input  logic [7:0]  i_cmd_data,
  input  logic        i_lcd_on,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic [31:0] o_io_lcd,
  output logic        o_busy
);

  // Counter only needs to reach the longest phase minus one.
  localparam int MAX_T = max2(max2(max2(eff_cycles(T_PWRUP), eff_cycles(T_SETUP)),
                                   max2(eff_cycles(T_EN),    eff_cycles(T_HOLD))),
                              max2(eff_cycles(T_EXEC), eff_cycles(T_EXEC_LONG)));
  localparam int CW = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [CW-1:0] LD_PWRUP     = CW'(eff_cycles(T_PWRUP) - 1);
  localparam logic [CW-1:0] LD_SETUP     = CW'(eff_cycles(T_SETUP) - 1);
  localparam logic [CW-1:0] LD_EN        = CW'(eff_cycles(T_EN) - 1);
  localparam logic [CW-1:0] LD_HOLD      = CW'(eff_cycles(T_HOLD) - 1);
  localparam logic [CW-1:0] LD_EXEC      = CW'(eff_cycles(T_EXEC) - 1);
  localparam logic [CW-1:0] LD_EXEC_LONG = CW'(eff_cycles(T_EXEC_LONG) - 1);

  lcd_state_e    state;
  lcd_state_e    state_next;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;
  logic          accept;

  // A command is taken only when idle; vld only gates register enables.
  assign accept = (state == IDLE) && i_cmd_vld;

  // State register; reset restarts the full power-up wait.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= PWRUP;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: each timed phase advances when its counter reaches zero.
  // NOTE: defaults first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      PWRUP:   if (tmr_done) state_next = IDLE;
      IDLE:    if (i_cmd_vld) state_next = SETUP;
      SETUP:   if (tmr_done) state_next = PULSE;
      PULSE:   if (tmr_done) state_next = HOLD;
      HOLD:    if (tmr_done) state_next = EXEC;
      EXEC:    if (tmr_done) state_next = IDLE;
      default: state_next = PWRUP;
    endcase
  end

  // Reload the phase counter on every state change and while in reset.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_next != state) begin
      tmr_load = 1'b1;
      case (state_next)
        PWRUP:   tmr_val = LD_PWRUP;
        SETUP:   tmr_val = LD_SETUP;
        PULSE:   tmr_val = LD_EN;
        HOLD:    tmr_val = LD_HOLD;
        EXEC:    tmr_val = is_long_cmd(o_lcd_rs, o_lcd_data) ? LD_EXEC_LONG : LD_EXEC;
        default: tmr_val = '0;
      endcase
    end
    if (!i_reset) begin
      tmr_load = 1'b1;
      tmr_val  = LD_PWRUP;
    end
  end

  lcd_timer #(
    .W (CW)
  ) u_timer (
    .i_clk      (i_clk),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_done     (tmr_done)
  );

  // Latch RS/DATA on acceptance and hold them until the next command.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_lcd_rs   <= 1'b0;
      o_lcd_data <= 8'h00;
    end else if (accept) begin
      o_lcd_rs   <= i_cmd_rs;
      o_lcd_data <= i_cmd_data;
    end
  end

  // Panel power follows the request one cycle later, regardless of the FSM.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_lcd_on <= 1'b0;
    end else begin
      o_lcd_on <= i_lcd_on;
    end
  end

  // EN and ready decode straight from the state register (glitch-free).
  assign o_lcd_en  = (state == PULSE);
  assign o_cmd_rdy = (state == IDLE);
  assign o_busy    = ~o_cmd_rdy;
  // Write-only: the busy flag is never read back from the panel.
  assign o_lcd_rw  = 1'b0;
  assign o_io_lcd  = {o_lcd_on, 20'b0, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data};

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Directed bench for lcd_bus_ctrl with shortened timings.
module tb_lcd_bus_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_cmd_vld;
  logic        o_cmd_rdy;
  logic        i_cmd_rs;
  logic [7:0]  i_cmd_data;
  logic        i_lcd_on;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic        o_lcd_on;
  logic [31:0] o_io_lcd;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;

  lcd_bus_ctrl #(
    .T_PWRUP     (10),
    .T_SETUP     (2),
    .T_EN        (4),
    .T_HOLD      (2),
    .T_EXEC      (8),
    .T_EXEC_LONG (40)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_cmd_vld  (i_cmd_vld),
    .o_cmd_rdy  (o_cmd_rdy),
    .i_cmd_rs   (i_cmd_rs),
    .i_cmd_data (i_cmd_data),
    .i_lcd_on   (i_lcd_on),
    .o_lcd_data (o_lcd_data),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_on   (o_lcd_on),
    .o_io_lcd   (o_io_lcd),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Issue one command (accepted on the next edge) and follow it until ready
  // returns after 'gap' cycles. With glitch set, vld pulses with 0x55 in PULSE.
  task automatic do_cmd(input logic rs, input logic [7:0] d, input int gap, input bit glitch);
    logic [31:0] io_exp;
    i_cmd_vld  = 1'b1;
    i_cmd_rs   = rs;
    i_cmd_data = d;
    tick();
    i_cmd_vld = 1'b0;
    io_exp = {1'b0, 20'b0, 1'b0, rs, 1'b0, d};
    check($sformatf("acc_data_%02h", d), 32'(o_lcd_data), 32'(d));
    check($sformatf("acc_rs_%02h", d), 32'(o_lcd_rs), 32'(rs));
    check($sformatf("setup_io_%02h", d), o_io_lcd, io_exp);
    for (int j = 1; j <= gap; j++) begin
      if (glitch && j == 3) begin
        i_cmd_vld  = 1'b1;
        i_cmd_rs   = 1'b0;
        i_cmd_data = 8'h55;
      end else if (glitch && j == 4) begin
        i_cmd_vld = 1'b0;
      end
      tick();
      check($sformatf("en_%02h_c%0d", d, j), 32'(o_lcd_en), 32'(j >= 2 && j <= 5));
      check($sformatf("rdy_%02h_c%0d", d, j), 32'(o_cmd_rdy), 32'(j == gap));
    end
    check($sformatf("busy_%02h", d), 32'(o_busy), 32'h0);
    check($sformatf("hold_data_%02h", d), 32'(o_lcd_data), 32'(d));
    check($sformatf("rw_%02h", d), 32'(o_lcd_rw), 32'h0);
  endtask

  initial begin
    i_reset    = 1'b0;
    i_cmd_vld  = 1'b0;
    i_cmd_rs   = 1'b0;
    i_cmd_data = 8'h00;
    i_lcd_on   = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_rdy",  32'(o_cmd_rdy),  32'h0);
    check("rst_busy", 32'(o_busy),     32'h1);
    check("rst_en",   32'(o_lcd_en),   32'h0);
    check("rst_rs",   32'(o_lcd_rs),   32'h0);
    check("rst_rw",   32'(o_lcd_rw),   32'h0);
    check("rst_data", 32'(o_lcd_data), 32'h0);
    check("rst_on",   32'(o_lcd_on),   32'h0);
    check("rst_io",   o_io_lcd,        32'h0);

    // Power-up with a request already pending: ready after exactly 10 cycles.
    i_reset    = 1'b1;
    i_cmd_vld  = 1'b1;
    i_cmd_rs   = 1'b1;
    i_cmd_data = 8'h41;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("pwrup_rdy_c%0d", k), 32'(o_cmd_rdy), 32'(k == 10));
      check($sformatf("pwrup_io_c%0d", k), o_io_lcd, 32'h0);
    end

    // Back-to-back command stream; each accepted on the cycle ready returns.
    do_cmd(1'b1, 8'h41, 16, 1'b0);
    do_cmd(1'b0, 8'h01, 48, 1'b0);
    do_cmd(1'b0, 8'h38, 16, 1'b0);
    do_cmd(1'b1, 8'h01, 16, 1'b0);
    do_cmd(1'b0, 8'h03, 48, 1'b0);
    do_cmd(1'b0, 8'h02, 48, 1'b0);
    do_cmd(1'b1, 8'h42, 16, 1'b1);

    // Power enable is a one-cycle registered copy of the request.
    i_lcd_on = 1'b1;
    check("on_before_edge", 32'(o_lcd_on), 32'h0);
    tick();
    check("on_after_edge", 32'(o_lcd_on), 32'h1);
    check("on_io", o_io_lcd, 32'h8000_0242);
    i_lcd_on = 1'b0;
    tick();
    check("off_after_edge", 32'(o_lcd_on), 32'h0);

    // Reset in the middle of the enable pulse.
    i_cmd_vld  = 1'b1;
    i_cmd_rs   = 1'b1;
    i_cmd_data = 8'h5A;
    tick();
    i_cmd_vld = 1'b0;
    tick();
    tick();
    check("mid_en_high", 32'(o_lcd_en), 32'h1);
    i_reset = 1'b0;
    tick();
    check("mid_rst_en",   32'(o_lcd_en),   32'h0);
    check("mid_rst_rdy",  32'(o_cmd_rdy),  32'h0);
    check("mid_rst_data", 32'(o_lcd_data), 32'h0);
    i_reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("rewait_rdy_c%0d", k), 32'(o_cmd_rdy), 32'(k == 10));
      check($sformatf("rewait_en_c%0d", k), 32'(o_lcd_en), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_bus_ctrl.md
LCD_BUS_CTRL -- requirements
Module: lcd_bus_ctrl

Interface
REQ-001 Parameters (name, default, meaning): T_PWRUP, 750000, power-up wait in cycles; T_SETUP, 2, RS/DATA setup cycles before EN; T_EN, 12, EN-high width in cycles; T_HOLD, 2, hold cycles after EN falls; T_EXEC, 2500, execution wait after a normal command; T_EXEC_LONG, 82000, execution wait after clear or home.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low, ports i_clk and i_reset.
REQ-003 i_clk  in  1  system clock, all state updates on the rising edge.
REQ-004 i_reset  in  1  synchronous active-low reset.
REQ-005 i_cmd_vld  in  1  command request from the store path.
REQ-006 o_cmd_rdy  out  1  block can accept a command.
REQ-007 i_cmd_rs  in  1  register select: 0 instruction, 1 data.
REQ-008 i_cmd_data  in  8  command or character byte.
REQ-009 i_lcd_on  in  1  backlight/power enable request.
REQ-010 o_lcd_data  out  8, o_lcd_rs  out  1, o_lcd_rw  out  1, o_lcd_en  out  1, o_lcd_on  out  1: HD44780 pins.
REQ-011 o_io_lcd  out  32  status word {o_lcd_on, 20'b0, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data}, used for CPU readback.
REQ-012 o_busy  out  1  equals the inverse of o_cmd_rdy.

Function
REQ-013 FSM states: PWRUP, IDLE, SETUP, PULSE, HOLD, EXEC.
REQ-014 PWRUP SHALL last T_PWRUP cycles, then go to IDLE; no command is accepted in PWRUP.
REQ-015 o_cmd_rdy SHALL be 1 only in IDLE; a command is accepted on an edge where i_cmd_vld and o_cmd_rdy are both 1.
REQ-016 On acceptance, i_cmd_rs and i_cmd_data SHALL be latched into o_lcd_rs and o_lcd_data and held until the next acceptance.
REQ-017 SETUP T_SETUP cycles with en=0, then PULSE T_EN cycles with en=1, then HOLD T_HOLD cycles with en=0, then EXEC, then IDLE.
REQ-018 EXEC SHALL last T_EXEC_LONG cycles when the latched rs=0 and data is 0x01, 0x02 or 0x03 (clear or home); otherwise it SHALL last T_EXEC cycles.
REQ-019 o_cmd_rdy SHALL reassert exactly T_SETUP+T_EN+T_HOLD+T_EXEC(_LONG) cycles after the accepting edge.
REQ-020 o_lcd_rw SHALL be constant 0; the block is write-only and does not poll the busy flag.
REQ-021 i_cmd_vld asserted outside IDLE SHALL be ignored; a request held across busy is accepted on the first IDLE cycle.
REQ-022 Back-to-back commands: if vld is held, the next acceptance occurs on the cycle rdy reasserts, with no extra bubble.
REQ-023 o_lcd_on SHALL be i_lcd_on registered by one cycle, independent of FSM state.
REQ-024 The phase counter SHALL be sized to hold the largest parameter value minus 1, count down to 0, and reload on every state change.
REQ-025 Any parameter equal to 0 SHALL be treated as 1 cycle.

Reset
REQ-026 Reset SHALL put the FSM in PWRUP with the counter loaded to T_PWRUP-1.
REQ-027 Reset SHALL drive o_cmd_rdy=0, o_busy=1, o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=0x00, o_lcd_on=0 and o_io_lcd=0.
REQ-028 Reset asserted mid-command SHALL drop EN on the next edge and abandon the command; the full power-up wait is repeated.

Structure
REQ-029 The shared package lcd_pkg SHALL hold the state enum lcd_state_e, the default timing constants, and the command codes LCD_CLEAR=0x01 and LCD_HOME=0x02.
REQ-030 Phase timing SHALL live in one sub-module, lcd_timer: a loadable down-counter with a done output.
REQ-031 The controller SHALL have no combinational path from i_cmd_vld to any LCD pin.

Verification (T_PWRUP=10, T_SETUP=2, T_EN=4, T_HOLD=2, T_EXEC=8, T_EXEC_LONG=40)
REQ-032 Release reset, hold vld=1 -> rdy=0 for 10 cycles, then 1; all pins 0 until acceptance.
REQ-033 Write rs=1, data=0x41 -> data/rs valid 2 cycles before EN rises; EN high exactly 4 cycles; rdy returns 16 cycles after acceptance; o_io_lcd shows 0x0000_0241 during SETUP.
REQ-034 Write rs=0, data=0x01, then rs=0, data=0x38 -> first rdy gap is 48 cycles, second is 16 cycles.
REQ-035 Write rs=1, data=0x01 -> short wait of 16 cycles, because rs=1 is data and not a clear command.
REQ-036 Pulse vld during PULSE with data 0x55 -> the pulse is ignored and o_lcd_data stays at the prior byte.
REQ-037 Assert reset during PULSE -> EN is 0 on the next cycle, and rdy stays 0 for 10 cycles after reset is released.
